// File: rtl/cmp42_pkg.sv
// Shared types for the 4:2-compressor sequential multiplier: FSM states, the
// default operand width and the bit-level 4:2 compressor function.
package cmp42_pkg;

  localparam int CMP42_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Two chained full adders; returns {cout, carry, sum}. cout does not depend on cin,
  // so a row of these has no ripple path.
  function automatic logic [2:0] cmp42_bit(input logic a, input logic b, input logic c,
                                           input logic d, input logic cin);
    logic s1, c1, s2, c2;
    s1 = a ^ b ^ c;
    c1 = (a & b) | (a & c) | (b & c);
    s2 = s1 ^ d ^ cin;
    c2 = (s1 & d) | (s1 & cin) | (d & cin);
    return {c1, c2, s2};
  endfunction

endpackage

// File: rtl/compres_row.sv
// One row of N bit-level 4:2 compressors; cout of bit i feeds cin of bit i+1,
// cin of bit 0 is zero and the top cout is dropped. Purely combinational.
module compres_row
  import cmp42_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  logic [2:0] bit_res;
  logic       cin_v;

  always_comb begin
    sum     = '0;
    carry   = '0;
    bit_res = '0;
    cin_v   = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit_res  = cmp42_bit(a[i], b[i], c[i], d[i], cin_v);
      sum[i]   = bit_res[0];
      carry[i] = bit_res[1];
      cin_v    = bit_res[2];
    end
  end

endmodule

// File: rtl/cmp42_mult_seq.sv
// Sequential unsigned W x W multiplier: two partial-product rows per cycle are folded
// into a redundant S/C pair by a 4:2 row, then resolved with one add.
// Optional macro CMP42_OUT_STALL_EN adds out_ready backpressure on the result.
module cmp42_mult_seq
  import cmp42_pkg::*;
#(
  parameter int W = CMP42_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  output logic [2*W-1:0] product,
  output logic           busy,
`ifdef CMP42_OUT_STALL_EN
  input  logic           out_ready,
`endif
  output state_e         dbg_state
);

  // Handshake: input accepted when in_valid && in_ready at a rising edge (in_ready only
  // in IDLE); result offered while out_valid (DONE only), consumed by out_ready if present.

  localparam int N    = 2 * W;
  localparam int HALF = W / 2;
  localparam int CW   = $clog2(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  state_e         state, state_nxt;
  logic [W-1:0]   a_reg, b_reg;
  logic [N-1:0]   s_q, c_q;
  logic [CW-1:0]  cnt;
  logic           accept;

  logic [CW:0]    j0, j1;
  logic [N-1:0]   a_ext, row0, row1;
  logic [N-1:0]   row_sum, row_carry;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Rows 2*cnt and 2*cnt+1 of the partial-product array.
  always_comb begin
    j0    = {cnt, 1'b0};
    j1    = {cnt, 1'b1};
    a_ext = {{W{1'b0}}, a_reg};
    row0  = b_reg[j0] ? (a_ext << j0) : '0;
    row1  = b_reg[j1] ? (a_ext << j1) : '0;
  end

  compres_row #(
    .N(N)
  ) u_row (
    .a    (s_q),
    .b    (c_q),
    .c    (row0),
    .d    (row1),
    .sum  (row_sum),
    .carry(row_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REDUCE;
      REDUCE:  if (cnt == CNT_LAST) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
`ifdef CMP42_OUT_STALL_EN
      DONE:    if (out_ready) state_nxt = IDLE;
`else
      DONE:    state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      s_q     <= '0;
      c_q     <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg <= a;
            b_reg <= b;
            s_q   <= '0;
            c_q   <= '0;
            cnt   <= '0;
          end
        end
        REDUCE: begin
          s_q <= row_sum;
          c_q <= row_carry << 1;
          // cnt parks on its last value so it never wraps inside REDUCE.
          if (cnt != CNT_LAST) cnt <= cnt + CW'(1);
        end
        FINAL:   product <= s_q + c_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp42_mult_seq.sv
// Bench for cmp42_mult_seq: directed table and corner sequences on W=8, plus
// randomized sweeps on W=4/8/16 checked against a plain a*b reference with latency.
module tb_cmp42_mult_seq;
  import cmp42_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst_n, in_valid, in_ready, out_valid, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;
  state_e         dbg_state;
`ifdef CMP42_OUT_STALL_EN
  logic           out_ready;
`endif

  cmp42_mult_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .product  (product),
    .busy     (busy),
`ifdef CMP42_OUT_STALL_EN
    .out_ready(out_ready),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [2*W-1:0] texp, input string tag);
    int w;
    int lat;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready before accept"}, in_ready, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, W / 2 + 1);
    chk({tag, " product"}, product, texp);
    chk({tag, " in_ready low in DONE"}, in_ready, 0);
    @(negedge clk);
    chk({tag, " out_valid one cycle"}, out_valid, 0);
    chk({tag, " in_ready after DONE"}, in_ready, 1);
    chk({tag, " product held"}, product, texp);
  endtask

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t tbl[8];

  // ---------------- randomized sweeps (own instances and resets) ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
    localparam int WW = 4 << gi;
    localparam int PW = 2 * WW;

    logic          rrst_n, riv, rir, rov, rbusy;
    logic [WW-1:0] ra, rb;
    logic [PW-1:0] rp;
    state_e        rst_dbg;
    logic [PW-1:0] exp_q[$];
    int            acc_q[$];
    bit            done_f = 1'b0;

    cmp42_mult_seq #(.W(WW)) u_dut (
      .clk      (clk),
      .rst_n    (rrst_n),
      .in_valid (riv),
      .in_ready (rir),
      .a        (ra),
      .b        (rb),
      .out_valid(rov),
      .product  (rp),
      .busy     (rbusy),
`ifdef CMP42_OUT_STALL_EN
      .out_ready(1'b1),
`endif
      .dbg_state(rst_dbg)
    );

    initial begin
      int gap;
      int w;
      rrst_n = 1'b0;
      riv = 1'b0;
      ra = '0;
      rb = '0;
      repeat (3) @(negedge clk);
      rrst_n = 1'b1;
      for (int n = 0; n < 1000; n++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          // Junk requests only while busy, where they must be ignored.
          riv = rir ? 1'b0 : 1'($urandom_range(0, 1));
          ra = WW'($urandom);
          rb = WW'($urandom);
        end
        @(negedge clk);
        w = 0;
        while (!rir && w < 60) begin
          riv = 1'($urandom_range(0, 1));
          ra = WW'($urandom);
          rb = WW'($urandom);
          @(negedge clk);
          w++;
        end
        chk($sformatf("rnd W%0d ready within bound", WW), rir, 1);
        riv = 1'b1;
        ra = WW'($urandom);
        rb = WW'($urandom);
        exp_q.push_back(PW'(ra) * PW'(rb));
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        riv = 1'b0;
        ra = WW'($urandom);
        rb = WW'($urandom);
      end
      repeat (WW + 6) @(negedge clk);
      chk($sformatf("rnd W%0d all results seen", WW), exp_q.size(), 0);
      done_f = 1'b1;
    end

    initial begin
      logic [PW-1:0] e;
      int t;
      forever begin
        @(negedge clk);
        if (rov) begin
          chk($sformatf("rnd W%0d result expected", WW), exp_q.size() > 0, 1);
          chk($sformatf("rnd W%0d out_valid only in DONE", WW), rst_dbg == DONE, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = acc_q.pop_front();
            chk($sformatf("rnd W%0d product", WW), rp, e);
            chk($sformatf("rnd W%0d latency", WW), cyc - t, WW / 2 + 1);
          end
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_ov;
    int t_ov[4];
    logic [2*W-1:0] p_ov[4];
    int rdy_low;
    int spur;
    int wt;

    tbl[0] = '{a: 8'd3,   b: 8'd5,   p: 16'd15};
    tbl[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
    tbl[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
    tbl[3] = '{a: 8'd1,   b: 8'd1,   p: 16'd1};
    tbl[4] = '{a: 8'd128, b: 8'd2,   p: 16'd256};
    tbl[5] = '{a: 8'd255, b: 8'd1,   p: 16'd255};
    tbl[6] = '{a: 8'd170, b: 8'd85,  p: 16'd14450};
    tbl[7] = '{a: 8'd200, b: 8'd0,   p: 16'd0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
`ifdef CMP42_OUT_STALL_EN
    out_ready = 1'b1;
`endif
    #12;
    chk("reset in_ready", in_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset product", product, 0);
    chk("reset state", dbg_state == IDLE, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) do_op(tbl[i].a, tbl[i].b, tbl[i].p, $sformatf("tbl%0d", i));

    // in_valid held high across an operation while a/b change mid-run.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd7;
    b = 8'd9;
    @(posedge clk);
    #1;
    n_ov = 0;
    rdy_low = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 2) begin
        a = 8'd3;
        b = 8'd4;
      end
      if (i <= 5 && !in_ready) rdy_low++;
      if (i == 7) begin
        in_valid = 1'b0;
        a = 8'hff;
        b = 8'hff;
      end
      if (out_valid && n_ov < 4) begin
        t_ov[n_ov] = i;
        p_ov[n_ov] = product;
        n_ov++;
      end
    end
    chk("held-valid result count", n_ov, 2);
    chk("held-valid ignored while busy", rdy_low, 6);
    chk("held-valid first time", t_ov[0], 5);
    chk("held-valid first product", p_ov[0], 63);
    chk("held-valid second time", t_ov[1], 12);
    chk("held-valid second product", p_ov[1], 12);

    // Reset pulse in REDUCE with cnt=2 abandons the operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd50;
    b = 8'd60;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset in REDUCE", dbg_state == REDUCE, 1);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset product", product, 0);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) spur++;
    end
    chk("no out_valid after abandoned op", spur, 0);
    do_op(8'd12, 8'd12, 16'd144, "after reset");

`ifdef CMP42_OUT_STALL_EN
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'd10;
    b = 8'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'd1;
    b = 8'd1;
    wt = 0;
    @(negedge clk);
    while (!out_valid && wt < 40) begin
      wt++;
      @(negedge clk);
    end
    chk("stall latency", wt, W / 2 + 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall out_valid held", out_valid, 1);
      chk("stall product held", product, 200);
      chk("stall in_ready low", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall release to IDLE", dbg_state == IDLE, 1);
    chk("stall release out_valid", out_valid, 0);
`endif

    wt = 0;
    while (!(g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f) && wt < 40000) begin
      @(negedge clk);
      wt++;
    end
    chk("random sweeps finished", g_rnd[0].done_f && g_rnd[1].done_f && g_rnd[2].done_f, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
